dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter_pkg.sv | 8 +
 rtl/dm_arbiter_rr_select.sv | 20 ++
 rtl/dm_arbiter.sv | 112 +++++++++++
 tb/tb_dm_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: shared FSM encoding and default widths for the data-memory arbiter
package dm_arbiter_pkg;
    localparam logic [1:0] ST_HOST  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;
endpackage

// File: rtl/dm_arbiter_rr_select.sv
// rr_select: one-hot pick of the first eligible requester at or after ptr, wrapping modulo N
module rr_select #(
    parameter int N = 4
) (
    input  logic [N-1:0] elig,
    input  logic [1:0]   ptr,
    output logic [N-1:0] grant,
    output logic         valid
);
    logic [2*N-1:0] dbl, gd;
    logic [N-1:0]   rot, ohr;
    always_comb begin
        dbl   = {elig, elig} >> ptr;
        rot   = dbl[N-1:0];
        ohr   = rot & (-rot);
        gd    = {ohr, ohr} << ptr;
        grant = gd[2*N-1:N];
        valid = |elig;
    end
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: hands a single data-memory port between a host loader and up to four round-robin cores
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int NCORES = 4,
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCORES-1:0]    core_status,
    input  logic                 run_start,
    input  logic [NCORES-1:0]    core_done,
    input  logic [NCORES-1:0]    core_req,
    input  logic [NCORES-1:0]    core_we,
    input  logic [NCORES*AW-1:0] core_addr,
    input  logic [NCORES*DW-1:0] core_wdata,
    output logic [NCORES-1:0]    core_grant,
    output logic [NCORES-1:0]    core_rvalid,
    output logic [DW-1:0]        core_rdata,
    input  logic                 host_we,
    input  logic [AW-1:0]        host_addr,
    input  logic [DW-1:0]        host_wdata,
    output logic [DW-1:0]        host_rdata,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    output logic                 terminate,
    output logic [31:0]          busy_cycles
);
    logic [1:0]        state_q, state_d, rr_ptr_q, rr_ptr_d, w;
    logic              drain_q, drain_d, term_q, term_d, mem_we_q, mem_we_d;
    logic              in_run, in_host, gnt_any, g_we, start_ok, all_done, sel_valid;
    logic [AW-1:0]     mem_addr_q, mem_addr_d, g_addr;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d, g_wdata;
    logic [NCORES-1:0] eligible, sel_grant, rd1_q, rd1_d, rd2_q, rd2_d;
    logic [31:0]       busy_q, busy_d;
    assign eligible = core_req & core_status & ~core_done;
    rr_select #(.N(NCORES)) u_sel (
        .elig  (eligible),
        .ptr   (rr_ptr_q),
        .grant (sel_grant),
        .valid (sel_valid)
    );
    always_comb begin
        in_run   = state_q == ST_RUN;
        in_host  = state_q == ST_HOST;
        gnt_any  = in_run & sel_valid;
        start_ok = in_host & run_start & (|core_status);
        all_done = (core_done & core_status) == core_status;
        w        = 2'd0;
        g_we     = 1'b0;
        g_addr   = '0;
        g_wdata  = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (sel_grant[i]) begin
                w       = 2'(i);
                g_we    = core_we[i];
                g_addr  = core_addr[i*AW +: AW];
                g_wdata = core_wdata[i*DW +: DW];
            end
        end
        state_d     = start_ok ? ST_RUN :
                      (in_run && all_done) ? ST_DRAIN :
                      (state_q == ST_DRAIN && drain_q) ? ST_HOST : state_q;
        drain_d     = (state_q == ST_DRAIN) & ~drain_q;
        rr_ptr_d    = !gnt_any ? rr_ptr_q : (int'(w) == NCORES - 1) ? 2'd0 : w + 2'd1;
        mem_we_d    = in_host ? host_we : gnt_any & g_we;
        mem_addr_d  = in_host ? host_addr : gnt_any ? g_addr : mem_addr_q;
        mem_wdata_d = in_host ? host_wdata : gnt_any ? g_wdata : mem_wdata_q;
        // reads ride a two-stage pipe so rvalid lines up with mem_rdata
        rd1_d       = gnt_any ? sel_grant & ~core_we : '0;
        rd2_d       = rd1_q;
        term_d      = start_ok ? 1'b0 : (state_q == ST_DRAIN && drain_q) ? 1'b1 : term_q;
        busy_d      = start_ok ? 32'd0 : (gnt_any && busy_q != '1) ? busy_q + 32'd1 : busy_q;
        core_grant  = in_run ? sel_grant : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HOST;
            drain_q     <= 1'b0;
            rr_ptr_q    <= 2'd0;
            term_q      <= 1'b0;
            busy_q      <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            rr_ptr_q    <= rr_ptr_d;
            term_q      <= term_d;
            busy_q      <= busy_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
        end
    end
    assign core_rvalid = rd2_q;
    assign core_rdata  = mem_rdata;
    assign host_rdata  = mem_rdata;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign terminate   = term_q;
    assign busy_cycles = busy_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: randomized and directed checks of dm_arbiter against a rule-level reference model
module tb_dm_arbiter;
    localparam int N = 4, AW = 16, DW = 16;
    logic clk = 1'b0, rst, run_start, host_we, mem_we, terminate;
    logic [N-1:0] core_status, core_done, core_req, core_we, core_grant, core_rvalid;
    logic [N*AW-1:0] core_addr;
    logic [N*DW-1:0] core_wdata;
    logic [DW-1:0] core_rdata, host_wdata, host_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] host_addr, mem_addr;
    logic [31:0] busy_cycles;
    always #5 clk = ~clk;
    dm_arbiter #(.NCORES(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .core_status(core_status), .run_start(run_start),
        .core_done(core_done), .core_req(core_req), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_grant(core_grant),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .terminate(terminate), .busy_cycles(busy_cycles)
    );
    logic [DW-1:0] ram [256];
    always @(posedge clk) begin
        if (rst) for (int i = 0; i < 256; i++) ram[i] <= DW'(i * 7 + 3);
        else if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[7:0]];
    end
    typedef struct { int core; logic [DW-1:0] data; int due; } rd_t;
    rd_t q[$];
    int tests = 0, fails = 0, ms, ptr, dend, cyc, g_cur, pct;
    bit rd_only;
    logic m_term, m_we;
    logic [31:0] m_busy;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] sh [256];
    logic [N-1:0] m_grant;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask
    function automatic int pick(input logic [N-1:0] elig, input int p);
        for (int k = 0; k < N; k++) if (elig[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction
    task automatic model_reset();
        ms = 0; ptr = 0; m_term = 0; m_busy = 0; m_we = 0; m_addr = 0; m_wdata = 0;
        q.delete();
        for (int i = 0; i < 256; i++) sh[i] = DW'(i * 7 + 3);
    endtask
    task automatic model_step();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit start;
        if (rst) model_reset();
        else begin
            start = ms == 0 && run_start && core_status != 0;
            if (ms == 0) begin
                m_we = host_we; m_addr = host_addr; m_wdata = host_wdata;
                if (host_we) sh[host_addr[7:0]] = host_wdata;
            end else if (g_cur >= 0) begin
                a = core_addr[g_cur*AW +: AW];
                d = core_wdata[g_cur*DW +: DW];
                m_we = core_we[g_cur]; m_addr = a; m_wdata = d;
                if (core_we[g_cur]) sh[a[7:0]] = d;
                else q.push_back('{core: g_cur, data: sh[a[7:0]], due: cyc + 2});
                ptr = (g_cur + 1) % N;
                if (m_busy != 32'hFFFF_FFFF) m_busy++;
            end else m_we = 0;
            if (start) begin ms = 1; m_term = 0; m_busy = 0; end
            else if (ms == 1 && (core_done & core_status) == core_status) begin ms = 2; dend = cyc + 2; end
            else if (ms == 2 && cyc == dend) begin ms = 0; m_term = 1; end
        end
        cyc++;
    endtask
    task automatic tick();
        logic [N-1:0] erv;
        logic [DW-1:0] erd;
        #1;
        g_cur = (ms == 1) ? pick(core_req & core_status & ~core_done, ptr) : -1;
        m_grant = '0;
        if (g_cur >= 0) m_grant[g_cur] = 1'b1;
        erv = '0; erd = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            erv[q[0].core] = 1'b1; erd = q[0].data;
            void'(q.pop_front());
        end
        check("core_grant", core_grant, m_grant);
        check("core_rvalid", core_rvalid, erv);
        if (erv != 0) check("core_rdata", core_rdata, erd);
        check("terminate", terminate, m_term);
        check("busy_cycles", busy_cycles, m_busy);
        check("mem_we", mem_we, m_we);
        check("mem_addr", mem_addr, m_addr);
        check("mem_wdata", mem_wdata, m_wdata);
        model_step();
        @(negedge clk);
    endtask
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (!core_req[i] || m_grant[i]) begin
                core_req[i] = $urandom_range(99) < pct;
                core_we[i] = rd_only ? 1'b0 : 1'($urandom_range(1));
                core_addr[i*AW +: AW] = AW'($urandom_range(63));
                core_wdata[i*DW +: DW] = DW'($urandom);
            end
        end
    endtask
    task automatic start_run(input logic [N-1:0] st);
        core_status = st; core_done = '0; run_start = 1'b1;
        drive(); tick();
        run_start = 1'b0;
    endtask
    task automatic finish_run();
        int n = 0;
        core_done = '1;
        while (ms != 0 && n < 10) begin drive(); tick(); n++; end
        check("terminate_after_drain", terminate, 1);
    endtask
    task automatic run_random(input int drate);
        int n = 0;
        logic [N-1:0] st;
        st = N'($urandom_range(1, 15));
        pct = $urandom_range(30, 100); rd_only = 1'($urandom_range(1) == 0 ? 1 : 0);
        start_run(st);
        while (ms != 0 && n < 400) begin
            drive();
            if (n > 150) core_done = '1;
            else for (int i = 0; i < N; i++) if ($urandom_range(999) < drate) core_done[i] = 1'b1;
            tick(); n++;
        end
        check("random_run_end", terminate, 1);
        repeat (2) tick();
    endtask
    initial begin
        rst = 1; run_start = 0; core_status = 0; core_done = 0; core_req = 0; core_we = 0;
        core_addr = 0; core_wdata = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        pct = 0; rd_only = 1; m_grant = 0; cyc = 0; g_cur = -1;
        model_reset();
        @(negedge clk);
        tick();
        rst = 0;
        host_we = 1; host_addr = 16'd5; host_wdata = 16'h00AB; tick();
        host_we = 0; tick();
        tick();
        check("host_rdata", host_rdata, 16'h00AB);
        core_status = '0; run_start = 1; host_addr = 16'd7; tick();
        run_start = 0; tick(); tick();
        check("ignored_start_term", terminate, 0);
        pct = 100; rd_only = 1;
        start_run(4'b0111);
        repeat (30) begin drive(); tick(); end
        finish_run();
        pct = 70; rd_only = 0;
        start_run(4'b0101);
        repeat (40) begin drive(); core_req[1] = 1'b1; tick(); end
        finish_run();
        core_req = '0; pct = 0;
        start_run(4'b0100);
        core_req = 4'b0100; core_we = '0; core_addr[2*AW +: AW] = 16'd3; tick();
        core_req = '0; finish_run();
        start_run(4'b0001);
        core_req = 4'b0001; core_we = '0; core_addr[0 +: AW] = 16'd9; tick();
        core_req = '0; rst = 1; tick();
        rst = 0; host_addr = 16'd11; repeat (3) tick();
        check("reset_abort_term", terminate, 0);
        check("reset_abort_busy", busy_cycles, 0);
        for (int r = 0; r < 8; r++) run_random($urandom_range(5, 40));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
